// File: rtl/pipe_ctrl.sv
// Pipeline control: arbitrates per-stage stall/flush requests into hold, bubble
// and redirect controls, tracks per-register valid bits and performance counters.
module pipe_ctrl #(
  parameter int unsigned NUM_STAGES = 5,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_STAGES-1:0] stall_req,
  input  logic [NUM_STAGES-1:0] flush_req,
  output logic [NUM_STAGES-1:0] hold,
  output logic [NUM_STAGES-1:0] bubble,
  output logic                  redirect,
  output logic [NUM_STAGES-1:0] valid,
  output logic                  retire,
  output logic [CNT_W-1:0]      cycle_cnt,
  output logic [CNT_W-1:0]      retire_cnt,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam int unsigned IDX_W = $clog2(NUM_STAGES);

  logic [NUM_STAGES-1:0] valid_q;
  logic [NUM_STAGES-1:0] valid_d;
  logic [NUM_STAGES-1:0] qual_mask;
  logic [NUM_STAGES-1:0] stall_q;
  logic [NUM_STAGES-1:0] flush_q;
  logic [NUM_STAGES-1:0] shifted;
  logic [IDX_W-1:0]      stall_idx;
  logic [IDX_W-1:0]      flush_idx;
  logic                  stall_any;
  logic                  flush_any;
  logic                  stall_eff;
  logic                  flush_eff;

  // Stage 0 is qualified only by reset; older stages also need a valid instruction.
  assign qual_mask = rst ? '0 : {valid_q[NUM_STAGES-1:1], 1'b1};
  assign stall_q   = stall_req & qual_mask;
  assign flush_q   = flush_req & qual_mask;
  assign shifted   = {valid_q[NUM_STAGES-2:0], 1'b1};
  assign valid     = valid_q;

  always_comb begin
    stall_idx = '0;
    flush_idx = '0;
    stall_any = 1'b0;
    flush_any = 1'b0;
    stall_eff = 1'b0;
    flush_eff = 1'b0;
    hold      = '0;
    bubble    = '0;
    redirect  = 1'b0;
    retire    = 1'b0;
    valid_d   = valid_q;

    // Ascending scan leaves the oldest requesting stage in the index.
    for (int i = 0; i < int'(NUM_STAGES); i++) begin
      if (stall_q[i]) begin
        stall_any = 1'b1;
        stall_idx = IDX_W'(i);
      end
      if (flush_q[i]) begin
        flush_any = 1'b1;
        flush_idx = IDX_W'(i);
      end
    end

    stall_eff = stall_any && (!flush_any || (stall_idx >= flush_idx));
    flush_eff = flush_any && (!stall_any || (flush_idx > stall_idx));
    redirect  = flush_eff;

    for (int i = 0; i < int'(NUM_STAGES); i++) begin
      if (stall_eff && (i <= int'(stall_idx)))
        hold[i] = 1'b1;
      if (stall_eff && (i == int'(stall_idx) + 1))
        bubble[i] = 1'b1;
      if (flush_eff && (i >= 1) && (i <= int'(flush_idx)))
        bubble[i] = 1'b1;
    end

    retire = !rst && valid_q[NUM_STAGES-1] && !hold[NUM_STAGES-1];

    for (int i = 0; i < int'(NUM_STAGES); i++) begin
      if (hold[i])
        valid_d[i] = valid_q[i];
      else if (bubble[i])
        valid_d[i] = 1'b0;
      else
        valid_d[i] = shifted[i];
    end
  end

  // Valid bits and wrapping performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= '0;
      cycle_cnt  <= '0;
      retire_cnt <= '0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else begin
      valid_q   <= valid_d;
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (retire)
        retire_cnt <= retire_cnt + CNT_W'(1);
      if (stall_eff)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_eff)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (N=5): fill, load-use stall, flush, arbitration,
// invalid-stage qualification, last-stage stall and reset during a stall.
module tb_pipe_ctrl;

  localparam int unsigned N = 5;
  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] stall_req;
  logic [N-1:0] flush_req;
  logic [N-1:0] hold;
  logic [N-1:0] bubble;
  logic         redirect;
  logic [N-1:0] valid;
  logic         retire;
  logic [W-1:0] cycle_cnt;
  logic [W-1:0] retire_cnt;
  logic [W-1:0] stall_cnt;
  logic [W-1:0] flush_cnt;

  int n_vec = 0;
  int n_err = 0;

  pipe_ctrl #(.NUM_STAGES(N), .CNT_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall_req  (stall_req),
    .flush_req  (flush_req),
    .hold       (hold),
    .bubble     (bubble),
    .redirect   (redirect),
    .valid      (valid),
    .retire     (retire),
    .cycle_cnt  (cycle_cnt),
    .retire_cnt (retire_cnt),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst       = 1'b1;
    stall_req = '0;
    flush_req = '0;
    tick();
    tick();
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_cycle", cycle_cnt, 32'd0);
    check("rst_retire_cnt", retire_cnt, 32'd0);

    // Requests during reset are ignored.
    stall_req = 5'b00001;
    #1;
    check("rst_hold", 32'(hold), 32'h0);
    stall_req = '0;

    // Fill: one more valid bit per edge; retire rises once valid[4] is set.
    rst = 1'b0;
    #1;
    check("fill_retire0", 32'(retire), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("fill_valid_%0d", i), 32'(valid), (32'd1 << i) - 32'd1);
      check($sformatf("fill_retire_%0d", i), 32'(retire), (i == 5) ? 32'd1 : 32'd0);
    end
    repeat (5) tick();
    // 10 edges: retire counted on edges 6..10.
    check("fill_cycle10", cycle_cnt, 32'd10);
    check("fill_retire_cnt", retire_cnt, 32'd5);
    tick();
    check("fill_cycle11", cycle_cnt, 32'd11);
    check("fill_retire_cnt11", retire_cnt, 32'd6);

    // Load-use stall at stage 2.
    stall_req = 5'b00100;
    #1;
    check("lu_hold", 32'(hold), 32'b00111);
    check("lu_bubble", 32'(bubble), 32'b01000);
    check("lu_redirect", 32'(redirect), 32'd0);
    check("lu_retire", 32'(retire), 32'd1);
    tick();
    stall_req = '0;
    check("lu_valid", 32'(valid), 32'b10111);
    check("lu_stall_cnt", stall_cnt, 32'd1);
    repeat (2) tick();
    check("lu_refill", 32'(valid), 32'b11111);

    // Branch flush from stage 1.
    flush_req = 5'b00010;
    #1;
    check("br_redirect", 32'(redirect), 32'd1);
    check("br_bubble", 32'(bubble), 32'b00010);
    check("br_hold", 32'(hold), 32'h0);
    tick();
    flush_req = '0;
    check("br_valid", 32'(valid), 32'b11101);
    check("br_flush_cnt", flush_cnt, 32'd1);
    repeat (4) tick();
    check("br_refill", 32'(valid), 32'b11111);

    // Conflict, older stall wins.
    stall_req = 5'b01000;
    flush_req = 5'b00010;
    #1;
    check("cs_hold", 32'(hold), 32'b01111);
    check("cs_bubble", 32'(bubble), 32'b10000);
    check("cs_redirect", 32'(redirect), 32'd0);
    tick();
    stall_req = '0;
    flush_req = '0;
    check("cs_stall_cnt", stall_cnt, 32'd2);
    check("cs_flush_cnt", flush_cnt, 32'd1);
    check("cs_valid", 32'(valid), 32'b01111);
    tick();
    check("cs_refill", 32'(valid), 32'b11111);

    // Conflict, older flush wins.
    stall_req = 5'b00010;
    flush_req = 5'b01000;
    #1;
    check("cf_redirect", 32'(redirect), 32'd1);
    check("cf_bubble", 32'(bubble), 32'b01110);
    check("cf_hold", 32'(hold), 32'h0);
    tick();
    stall_req = '0;
    flush_req = '0;
    check("cf_stall_cnt", stall_cnt, 32'd2);
    check("cf_flush_cnt", flush_cnt, 32'd2);
    check("cf_valid", 32'(valid), 32'b10001);

    // Stall from an empty stage is ignored.
    stall_req = 5'b01000;
    #1;
    check("inv_hold", 32'(hold), 32'h0);
    check("inv_bubble", 32'(bubble), 32'h0);
    tick();
    stall_req = '0;
    check("inv_stall_cnt", stall_cnt, 32'd2);
    check("inv_valid", 32'(valid), 32'b00011);
    repeat (3) tick();
    check("inv_refill", 32'(valid), 32'b11111);

    // Stall at the last stage freezes everything, no bubble, no retire.
    stall_req = 5'b10000;
    #1;
    check("ls_hold", 32'(hold), 32'b11111);
    check("ls_bubble", 32'(bubble), 32'h0);
    check("ls_retire", 32'(retire), 32'd0);
    tick();
    stall_req = '0;
    check("ls_valid", 32'(valid), 32'b11111);
    check("ls_stall_cnt", stall_cnt, 32'd3);

    // Flush from stage 0 only redirects.
    flush_req = 5'b00001;
    #1;
    check("f0_redirect", 32'(redirect), 32'd1);
    check("f0_bubble", 32'(bubble), 32'h0);
    check("f0_hold", 32'(hold), 32'h0);
    tick();
    flush_req = '0;
    check("f0_valid", 32'(valid), 32'b11111);
    check("f0_flush_cnt", flush_cnt, 32'd3);

    // Reset lands on the third cycle of a stall.
    stall_req = 5'b00100;
    tick();
    check("rs_stall1", stall_cnt, 32'd4);
    tick();
    check("rs_stall2", stall_cnt, 32'd5);
    rst = 1'b1;
    #1;
    check("rs_hold", 32'(hold), 32'h0);
    check("rs_bubble", 32'(bubble), 32'h0);
    check("rs_retire", 32'(retire), 32'd0);
    tick();
    check("rs_valid", 32'(valid), 32'h0);
    check("rs_cycle", cycle_cnt, 32'd0);
    check("rs_retire_cnt", retire_cnt, 32'd0);
    check("rs_stall_cnt", stall_cnt, 32'd0);
    check("rs_flush_cnt", flush_cnt, 32'd0);
    rst       = 1'b0;
    stall_req = '0;
    tick();
    check("rs_restart_valid", 32'(valid), 32'b00001);
    check("rs_restart_cycle", cycle_cnt, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
